// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// Programmable VGA timing generator. A pixel counter (h_cnt) and a line
// counter (v_cnt) walk the frame described by the latched timing config;
// the decoded sync, display-enable and coordinate outputs are registered,
// so they lag the counters by one clock.
//
// Timing changes are announced by flipping cfg_tgl_i. While idle a valid
// config is latched at once. While running it is only marked pending and
// is latched from the live hd_i..vb_i inputs at the next frame wrap, so a
// frame is never torn. A config with a zero display or retrace length is
// rejected with a one-cycle cfg_err_o pulse.
//
// Ports
//   clk_i          in   sole clock, rising edge
//   arstn_i        in   synchronous active-low reset
//   hd_i/hf_i/hr_i/hb_i  in  horizontal display/front porch/retrace/back
//                       porch, in pixels
//   vd_i/vf_i/vr_i/vb_i  in  vertical display/front porch/retrace/back
//                       porch, in lines
//   cfg_tgl_i      in   any level change announces new timing
//   en_i           in   run enable
//   hsync_o        out  horizontal sync, active level HSYNC_POL
//   vsync_o        out  vertical sync, active level VSYNC_POL
//   de_o           out  display enable
//   x_o, y_o       out  pixel coordinates
//   frame_start_o  out  one-cycle pulse for pixel (0,0)
//   cfg_err_o      out  one-cycle pulse when a config is rejected
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int   VGA_MAX_H_WIDTH = 12,
    parameter int   VGA_MAX_V_WIDTH = 11,
    parameter logic HSYNC_POL       = 1'b1,
    parameter logic VSYNC_POL       = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    input  logic [VGA_MAX_H_WIDTH-1:0] hd_i,
    input  logic [VGA_MAX_H_WIDTH-1:0] hf_i,
    input  logic [VGA_MAX_H_WIDTH-1:0] hr_i,
    input  logic [VGA_MAX_H_WIDTH-1:0] hb_i,
    input  logic [VGA_MAX_V_WIDTH-1:0] vd_i,
    input  logic [VGA_MAX_V_WIDTH-1:0] vf_i,
    input  logic [VGA_MAX_V_WIDTH-1:0] vr_i,
    input  logic [VGA_MAX_V_WIDTH-1:0] vb_i,
    input  logic                       cfg_tgl_i,
    input  logic                       en_i,
    output logic                       hsync_o,
    output logic                       vsync_o,
    output logic                       de_o,
    output logic [VGA_MAX_H_WIDTH-1:0] x_o,
    output logic [VGA_MAX_V_WIDTH-1:0] y_o,
    output logic                       frame_start_o,
    output logic                       cfg_err_o
);

    localparam int HW = VGA_MAX_H_WIDTH;
    localparam int VW = VGA_MAX_V_WIDTH;
    // Sum of four fields needs two extra bits to never overflow.
    localparam int HT = VGA_MAX_H_WIDTH + 2;
    localparam int VT = VGA_MAX_V_WIDTH + 2;

    localparam logic [HT-1:0] H_ONE = {{(HT-1){1'b0}}, 1'b1};
    localparam logic [VT-1:0] V_ONE = {{(VT-1){1'b0}}, 1'b1};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]    state_q, state_d;
    logic [HT-1:0] h_cnt_q, h_cnt_d;
    logic [VT-1:0] v_cnt_q, v_cnt_d;
    logic          pend_q,  pend_d;
    logic          tgl_q;

    // Latched (active) timing config.
    logic [HW-1:0] hd_q, hf_q, hr_q, hb_q;
    logic [VW-1:0] vd_q, vf_q, vr_q, vb_q;
    logic          cfg_load;

    // Registered outputs.
    logic          hsync_q, vsync_q, de_q, fs_q, err_q, err_d;
    logic [HW-1:0] x_q;
    logic [VW-1:0] y_q;

    // -----------------------------------------------------------------------
    // Config event detection and validity
    // -----------------------------------------------------------------------
    logic cfg_evt;
    logic in_valid;
    logic held_valid;
    logic evt_ok;

    assign cfg_evt    = cfg_tgl_i ^ tgl_q;
    assign in_valid   = (hd_i != '0) && (hr_i != '0) &&
                        (vd_i != '0) && (vr_i != '0);
    // Reset zeroes the latched config, so this also encodes "a valid
    // config has been latched since reset".
    assign held_valid = (hd_q != '0) && (hr_q != '0) &&
                        (vd_q != '0) && (vr_q != '0);
    assign evt_ok     = cfg_evt && in_valid;

    // -----------------------------------------------------------------------
    // Frame geometry from the latched config, all in widened arithmetic
    // -----------------------------------------------------------------------
    logic [HT-1:0] hd_x, hs_start, hs_end, htot;
    logic [VT-1:0] vd_x, vs_start, vs_end, vtot;

    assign hd_x     = {2'b00, hd_q};
    assign hs_start = hd_x + {2'b00, hf_q};
    assign hs_end   = hs_start + {2'b00, hr_q};
    assign htot     = hs_end + {2'b00, hb_q};

    assign vd_x     = {2'b00, vd_q};
    assign vs_start = vd_x + {2'b00, vf_q};
    assign vs_end   = vs_start + {2'b00, vr_q};
    assign vtot     = vs_end + {2'b00, vb_q};

    logic h_last, v_last, frame_wrap;

    assign h_last     = (h_cnt_q == htot - H_ONE);
    assign v_last     = (v_cnt_q == vtot - V_ONE);
    assign frame_wrap = h_last && v_last;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        pend_d   = pend_q;
        cfg_load = 1'b0;
        err_d    = cfg_evt && !in_valid;

        case (state_q)
            ST_IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (evt_ok) begin
                    // Idle: nothing on screen to protect, take it now. The
                    // live inputs supersede anything still pending.
                    cfg_load = 1'b1;
                    pend_d   = 1'b0;
                    if (en_i) begin
                        state_d = ST_RUN;
                    end
                end else if (en_i) begin
                    if (pend_q) begin
                        // Resume with the config announced while running.
                        pend_d = 1'b0;
                        if (in_valid) begin
                            cfg_load = 1'b1;
                            state_d  = ST_RUN;
                        end else begin
                            err_d = 1'b1;
                            if (held_valid) begin
                                state_d = ST_RUN;
                            end
                        end
                    end else if (held_valid) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (!en_i) begin
                    // Stop immediately; latched config and pending survive.
                    state_d = ST_IDLE;
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                    if (evt_ok) begin
                        pend_d = 1'b1;
                    end
                end else begin
                    if (h_last) begin
                        h_cnt_d = '0;
                        if (v_last) begin
                            v_cnt_d = '0;
                        end else begin
                            v_cnt_d = v_cnt_q + V_ONE;
                        end
                    end else begin
                        h_cnt_d = h_cnt_q + H_ONE;
                    end

                    if (frame_wrap) begin
                        // An event landing on the wrap itself is honoured
                        // here too. Values come from the live inputs, so
                        // the last announcement in the frame wins.
                        if (pend_q || evt_ok) begin
                            pend_d = 1'b0;
                            if (in_valid) begin
                                cfg_load = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end else if (evt_ok) begin
                        pend_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                h_cnt_d = '0;
                v_cnt_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode from the current counters
    // -----------------------------------------------------------------------
    logic run;
    logic de_c, hs_c, vs_c, fs_c;

    assign run  = (state_q == ST_RUN);
    assign de_c = (h_cnt_q < hd_x) && (v_cnt_q < vd_x);
    assign hs_c = (h_cnt_q >= hs_start) && (h_cnt_q < hs_end);
    assign vs_c = (v_cnt_q >= vs_start) && (v_cnt_q < vs_end);
    assign fs_c = (h_cnt_q == '0) && (v_cnt_q == '0);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples values from before this edge.
        if (!arstn_i) begin
            state_q <= ST_IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            pend_q  <= 1'b0;
            tgl_q   <= 1'b0;
            // NOTE: the config registers are reset on purpose: a zeroed
            // config reads as invalid, which keeps the generator idle until
            // a fresh config event arrives after reset.
            hd_q    <= '0;
            hf_q    <= '0;
            hr_q    <= '0;
            hb_q    <= '0;
            vd_q    <= '0;
            vf_q    <= '0;
            vr_q    <= '0;
            vb_q    <= '0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            pend_q  <= pend_d;
            tgl_q   <= cfg_tgl_i;
            err_q   <= err_d;

            if (cfg_load) begin
                hd_q <= hd_i;
                hf_q <= hf_i;
                hr_q <= hr_i;
                hb_q <= hb_i;
                vd_q <= vd_i;
                vf_q <= vf_i;
                vr_q <= vr_i;
                vb_q <= vb_i;
            end

            if (run) begin
                hsync_q <= hs_c ? HSYNC_POL : ~HSYNC_POL;
                vsync_q <= vs_c ? VSYNC_POL : ~VSYNC_POL;
                de_q    <= de_c;
                // Coordinates only matter inside the display area, which
                // always fits the narrower output width.
                x_q     <= h_cnt_q[HW-1:0];
                y_q     <= v_cnt_q[VW-1:0];
                fs_q    <= fs_c;
            end else begin
                hsync_q <= ~HSYNC_POL;
                vsync_q <= ~VSYNC_POL;
                de_q    <= 1'b0;
                x_q     <= '0;
                y_q     <= '0;
                fs_q    <= 1'b0;
            end
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign frame_start_o = fs_q;
    assign cfg_err_o     = err_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Directed bench for vga_sync_gen. Inputs are driven and outputs sampled on
// the falling clock edge. Every output sample is packed into one word and
// compared against a value computed from the timing fields the bench
// itself chose.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic [11:0] hd_i, hf_i, hr_i, hb_i;
    logic [10:0] vd_i, vf_i, vr_i, vb_i;
    logic        cfg_tgl_i;
    logic        en_i;
    logic        hsync_o, vsync_o, de_o, frame_start_o, cfg_err_o;
    logic [11:0] x_o;
    logic [10:0] y_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    vga_sync_gen dut (
        .clk_i         (clk_i),
        .arstn_i       (arstn_i),
        .hd_i          (hd_i),
        .hf_i          (hf_i),
        .hr_i          (hr_i),
        .hb_i          (hb_i),
        .vd_i          (vd_i),
        .vf_i          (vf_i),
        .vr_i          (vr_i),
        .vb_i          (vb_i),
        .cfg_tgl_i     (cfg_tgl_i),
        .en_i          (en_i),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .de_o          (de_o),
        .x_o           (x_o),
        .y_o           (y_o),
        .frame_start_o (frame_start_o),
        .cfg_err_o     (cfg_err_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (err fs vs hs de | y | x)",
                     tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {4'b0000, cfg_err_o, frame_start_o, vsync_o, hsync_o, de_o,
                y_o, x_o};
    endfunction

    function automatic logic [31:0] pack(input int err, input int fs,
                                         input int vs, input int hs,
                                         input int de, input int y,
                                         input int x);
        return {4'b0000, 1'(err), 1'(fs), 1'(vs), 1'(hs), 1'(de),
                11'(y), 12'(x)};
    endfunction

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic drive_cfg(input int hd, input int hf, input int hr,
                             input int hb, input int vd, input int vf,
                             input int vr, input int vb);
        hd_i = 12'(hd); hf_i = 12'(hf); hr_i = 12'(hr); hb_i = 12'(hb);
        vd_i = 11'(vd); vf_i = 11'(vf); vr_i = 11'(vr); vb_i = 11'(vb);
    endtask

    // Checks one whole frame, starting at the sample that should carry
    // frame_start_o. Optional stimulus at given sample indices:
    //   ev_a   : flip the toggle (inputs already set by the caller)
    //   ev_b   : set hd_i = hd_b and flip the toggle
    //   err_at : present hr_i = 0 with a toggle, restore hr_i afterwards
    task automatic check_frame(input int hd, input int hf, input int hr,
                               input int hb, input int vd, input int vf,
                               input int vr, input int vb,
                               input int ev_a, input int ev_b,
                               input int hd_b, input int err_at,
                               input string tag);
        int          ht;
        int          vt;
        logic [11:0] saved_hr;
        ht = hd + hf + hr + hb;
        vt = vd + vf + vr + vb;
        saved_hr = hr_i;
        for (int i = 0; i < ht * vt; i++) begin
            int x;
            int y;
            int e_de;
            int e_hs;
            int e_vs;
            int e_err;
            x     = i % ht;
            y     = i / ht;
            e_de  = (x < hd && y < vd) ? 1 : 0;
            e_hs  = (x >= hd + hf && x < hd + hf + hr) ? 1 : 0;
            e_vs  = (y >= vd + vf && y < vd + vf + vr) ? 1 : 0;
            e_err = (err_at >= 0 && i == err_at + 1) ? 1 : 0;
            check(tag, obs(),
                  pack(e_err, (i == 0) ? 1 : 0, e_vs, e_hs, e_de, y, x));
            if (i == ev_a) cfg_tgl_i = ~cfg_tgl_i;
            if (i == ev_b) begin
                hd_i      = 12'(hd_b);
                cfg_tgl_i = ~cfg_tgl_i;
            end
            if (i == err_at) begin
                saved_hr  = hr_i;
                hr_i      = '0;
                cfg_tgl_i = ~cfg_tgl_i;
            end
            if (err_at >= 0 && i == err_at + 1) hr_i = saved_hr;
            tick();
        end
    endtask

    logic [31:0] idle_vec;

    initial begin
        idle_vec  = pack(0, 0, 0, 0, 0, 0, 0);
        arstn_i   = 1'b0;
        en_i      = 1'b0;
        cfg_tgl_i = 1'b0;
        drive_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check("reset_state", obs(), idle_vec);

        // Enabled but no config since reset: must stay idle.
        arstn_i = 1'b1;
        en_i    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_no_cfg", obs(), idle_vec);
        end

        // First config: frame_start two samples after the toggle.
        drive_cfg(4, 1, 2, 1, 3, 1, 1, 1);
        cfg_tgl_i = ~cfg_tgl_i;
        tick();
        check("start_latency", obs(), idle_vec);
        tick();
        check_frame(4, 1, 2, 1, 3, 1, 1, 1, -1, -1, 0, -1, "frame_a");

        // Mid-frame change to hd=6: current frame finishes unchanged.
        hd_i = 12'd6;
        check_frame(4, 1, 2, 1, 3, 1, 1, 1, 10, -1, 0, -1, "frame_a_pend");
        check_frame(6, 1, 2, 1, 3, 1, 1, 1, -1, -1, 0, -1, "frame_b");

        // Rejected config (hr=0): one error pulse, timing unchanged.
        check_frame(6, 1, 2, 1, 3, 1, 1, 1, -1, -1, 0, 7, "frame_b_err");
        check_frame(6, 1, 2, 1, 3, 1, 1, 1, -1, -1, 0, -1, "frame_b_after");

        // Two toggles in one frame: only the last values (hd=2) apply.
        hd_i = 12'd8;
        check_frame(6, 1, 2, 1, 3, 1, 1, 1, 3, 20, 2, -1, "frame_b_two");
        check_frame(2, 1, 2, 1, 3, 1, 1, 1, -1, -1, 0, -1, "frame_c");

        // Toggle landing exactly on the frame wrap applies at that wrap.
        hd_i = 12'd4;
        check_frame(2, 1, 2, 1, 3, 1, 1, 1, 34, -1, 0, -1, "frame_c_wrap");
        check_frame(4, 1, 2, 1, 3, 1, 1, 1, -1, -1, 0, -1, "frame_a_back");

        // Pending change, then en_i low for 3 cycles mid-line.
        check("en_f0", obs(), pack(0, 1, 0, 0, 1, 0, 0));
        hd_i      = 12'd6;
        cfg_tgl_i = ~cfg_tgl_i;
        tick();
        check("en_f1", obs(), pack(0, 0, 0, 0, 1, 0, 1));
        en_i = 1'b0;
        tick();
        check("en_off_lag", obs(), pack(0, 0, 0, 0, 1, 0, 2));
        tick();
        check("en_off_idle", obs(), idle_vec);
        tick();
        check("en_off_idle", obs(), idle_vec);
        en_i = 1'b1;
        tick();
        check("en_resume_wait", obs(), idle_vec);
        tick();
        check_frame(6, 1, 2, 1, 3, 1, 1, 1, -1, -1, 0, -1, "frame_resume");

        // Reset mid-frame; toggle driven low during reset so release sees
        // no level change.
        repeat (10) tick();
        arstn_i   = 1'b0;
        cfg_tgl_i = 1'b0;
        tick();
        check("reset_mid", obs(), idle_vec);
        tick();
        arstn_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("reset_quiet", obs(), idle_vec);
        end

        drive_cfg(4, 1, 2, 1, 3, 1, 1, 1);
        cfg_tgl_i = 1'b1;
        tick();
        check("restart_latency", obs(), idle_vec);
        tick();
        check_frame(4, 1, 2, 1, 3, 1, 1, 1, -1, -1, 0, -1, "frame_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
